// File: rtl/cpu_mc_ctrl.sv
// rtl/cpu_mc_ctrl.sv - multicycle controller: PC, IR, data-address register, decoder and control FSM
// Optional feature macro: CPU_ILLEGAL_TRAP_EN (undefined opcode sets sticky illegal and halts;
//   when undefined, an undefined opcode behaves as a NOP and illegal is tied to 0).
// Ports:
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   read_data, mem_ready          memory read data and access-complete handshake
//   mem_cmd, mem_addr             memory command (00 none, 01 read, 10 write) and address
//   datapath_out, Z, N, V         datapath C register and status flags
//   write, loada..bsel            datapath enables and selects
//   nsel, vsel, readnum, writenum register-file index select and write-back source
//   ALUop, shift, sximm5, sximm8  instruction fields for the datapath
//   shift_ctrl                    1 while IR holds LDR or STR
//   pc, halted, illegal           current PC and status
// ADDR_W must be at least 9 so the branch offset sign extension is well formed.
module cpu_mc_ctrl #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] datapath_out,
    input  logic              Z,
    input  logic              N,
    input  logic              V,
    output logic              write,
    output logic              loada,
    output logic              loadb,
    output logic              loadc,
    output logic              loads,
    output logic              asel,
    output logic              bsel,
    output logic [1:0]        nsel,
    output logic [1:0]        vsel,
    output logic [2:0]        readnum,
    output logic [2:0]        writenum,
    output logic [1:0]        ALUop,
    output logic [1:0]        shift,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8,
    output logic              shift_ctrl,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal
);

    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    typedef enum logic [3:0] {
        S_RST, S_IF, S_UPDPC, S_DECODE, S_LOADA, S_LOADB, S_LOADC, S_ADDRC,
        S_ADDR, S_MEMRD, S_STLB, S_STLC, S_MEMWR, S_WRITE, S_BRANCH, S_HALT
    } state_t;

    state_t            state, next_state;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] dar;
    logic [4:0]        opc;
    logic              is_movi, is_movr, is_mvn, is_add, is_cmp, is_and;
    logic              is_ldr, is_str, is_b, is_halt, is_defined;
    logic              taken;
    logic [ADDR_W-1:0] br_off;
    logic              unused_bits;

    assign opc     = ir[15:11];
    assign is_movi = (opc == 5'b11010);
    assign is_movr = (opc == 5'b11000);
    assign is_mvn  = (opc == 5'b10111);
    assign is_add  = (opc == 5'b10100);
    assign is_cmp  = (opc == 5'b10101);
    assign is_and  = (opc == 5'b10110);
    assign is_ldr  = (opc == 5'b01100);
    assign is_str  = (opc == 5'b10000);
    assign is_b    = (opc == 5'b00100);
    assign is_halt = (opc == 5'b11100);
    assign is_defined = is_movi | is_movr | is_mvn | is_add | is_cmp | is_and |
                        is_ldr | is_str | is_b | is_halt;

    assign ALUop      = ir[12:11];
    assign shift      = ir[4:3];
    assign sximm5     = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign sximm8     = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign shift_ctrl = is_ldr | is_str;
    assign br_off     = {{(ADDR_W-8){ir[7]}}, ir[7:0]};

    // Upper datapath/read bits are intentionally not consumed by the controller.
    assign unused_bits = ^{datapath_out, read_data};

    always_comb begin
        taken = 1'b0;
        case (ir[10:8])
            3'b000:  taken = 1'b1;
            3'b001:  taken = Z;
            3'b010:  taken = ~Z;
            3'b011:  taken = N ^ V;
            3'b100:  taken = (N ^ V) | Z;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (nsel)
            2'b00:   readnum = ir[10:8];
            2'b01:   readnum = ir[7:5];
            2'b10:   readnum = ir[2:0];
            default: readnum = 3'b000;
        endcase
        writenum = readnum;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RST;
            pc    <= RESET_PC_V;
            ir    <= 16'h0000;
            dar   <= '0;
        end else begin
            state <= next_state;
            if (state == S_IF && mem_ready)
                ir <= read_data[15:0];
            if (state == S_UPDPC)
                pc <= pc + ADDR_W'(1);
            // pc already points past the branch, so the offset is relative to pc+1.
            if (state == S_BRANCH && taken)
                pc <= pc + br_off;
            if (state == S_ADDR)
                dar <= datapath_out[ADDR_W-1:0];
        end
    end

`ifdef CPU_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (state == S_DECODE && !is_defined)
            illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        next_state = state;
        mem_cmd    = 2'b00;
        mem_addr   = dar;
        write      = 1'b0;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        nsel       = 2'b00;
        vsel       = 2'b00;
        halted     = 1'b0;
        case (state)
            S_RST:    next_state = S_IF;
            S_IF: begin
                mem_cmd  = 2'b01;
                mem_addr = pc;
                if (mem_ready) next_state = S_UPDPC;
            end
            S_UPDPC:  next_state = S_DECODE;
            S_DECODE: begin
                if (is_movi)                                     next_state = S_WRITE;
                else if (is_movr | is_mvn)                       next_state = S_LOADB;
                else if (is_add | is_cmp | is_and | is_ldr | is_str) next_state = S_LOADA;
                else if (is_b)                                   next_state = S_BRANCH;
                else if (is_halt)                                next_state = S_HALT;
`ifdef CPU_ILLEGAL_TRAP_EN
                else                                             next_state = S_HALT;
`else
                else                                             next_state = S_IF;
`endif
            end
            S_LOADA: begin
                loada      = 1'b1;
                next_state = (is_ldr | is_str) ? S_ADDRC : S_LOADB;
            end
            S_LOADB: begin
                nsel       = 2'b10;
                loadb      = 1'b1;
                next_state = S_LOADC;
            end
            S_LOADC: begin
                if (is_cmp) begin
                    loads      = 1'b1;
                    next_state = S_IF;
                end else begin
                    loadc      = 1'b1;
                    asel       = is_movr;
                    next_state = S_WRITE;
                end
            end
            S_ADDRC: begin
                bsel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_ADDR;
            end
            S_ADDR:   next_state = is_ldr ? S_MEMRD : S_STLB;
            S_MEMRD: begin
                mem_cmd = 2'b01;
                nsel    = 2'b01;
                vsel    = 2'b11;
                // Rd captures read_data on the same edge that completes the access.
                write   = mem_ready;
                if (mem_ready) next_state = S_IF;
            end
            S_STLB: begin
                nsel       = 2'b01;
                loadb      = 1'b1;
                next_state = S_STLC;
            end
            S_STLC: begin
                asel       = 1'b1;
                loadc      = 1'b1;
                next_state = S_MEMWR;
            end
            S_MEMWR: begin
                mem_cmd = 2'b10;
                if (mem_ready) next_state = S_IF;
            end
            S_WRITE: begin
                write      = 1'b1;
                nsel       = is_movi ? 2'b00 : 2'b01;
                vsel       = is_movi ? 2'b10 : 2'b00;
                next_state = S_IF;
            end
            S_BRANCH: next_state = S_IF;
            S_HALT:   halted = 1'b1;
            default:  next_state = S_RST;
        endcase
    end

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// tb/tb_cpu_mc_ctrl.sv - self-checking bench for cpu_mc_ctrl with an instruction-level reference model
module tb_cpu_mc_ctrl;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 9;
    localparam int RESET_PC = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [DATA_W-1:0] read_data = '0;
    logic [DATA_W-1:0] datapath_out = '0;
    logic mem_ready = 1'b0;
    logic Z = 1'b0, N = 1'b0, V = 1'b0;
    logic [1:0] mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] nsel, vsel;
    logic [2:0] readnum, writenum;
    logic [1:0] ALUop, shift;
    logic [DATA_W-1:0] sximm5, sximm8;
    logic shift_ctrl;
    logic [ADDR_W-1:0] pc;
    logic halted, illegal;

    int n_cmp = 0;
    int n_bad = 0;
    int pc_m = RESET_PC;

    logic [15:0] cur_instr;
    int cur_fw, cur_mw, acc_idx, waits_left;
    bit in_access;

    cpu_mc_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .read_data(read_data), .mem_ready(mem_ready),
        .mem_cmd(mem_cmd), .mem_addr(mem_addr), .datapath_out(datapath_out),
        .Z(Z), .N(N), .V(V), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .nsel(nsel),
        .vsel(vsel), .readnum(readnum), .writenum(writenum), .ALUop(ALUop),
        .shift(shift), .sximm5(sximm5), .sximm8(sximm8), .shift_ctrl(shift_ctrl),
        .pc(pc), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic start_instr(input logic [15:0] instr, input int fw, input int mw);
        cur_instr = instr; cur_fw = fw; cur_mw = mw;
        acc_idx = 0; in_access = 0; waits_left = 0;
    endtask

    // Memory responder: first access of an instruction is the fetch, second the data access.
    task automatic drive_inputs();
        read_data = (acc_idx == 0) ? cur_instr : DATA_W'($urandom);
        if (mem_cmd != 2'b00) begin
            if (!in_access) begin
                in_access = 1;
                waits_left = (acc_idx == 0) ? cur_fw : cur_mw;
            end
            if (waits_left > 0) begin
                mem_ready = 1'b0; waits_left--;
            end else begin
                mem_ready = 1'b1; in_access = 0; acc_idx++;
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        pc_m = RESET_PC;
    endtask

    // Runs one instruction from the first IF cycle to the first cycle of the next fetch.
    task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                             input logic [DATA_W-1:0] dpo, input logic z, input logic n, input logic v);
        logic [4:0] opc;
        logic [2:0] rn, rd, rm, exp_wn, exp_rnb, wn, rn_a, rn_b;
        logic [1:0] exp_vs, vs;
        logic [ADDR_W-1:0] daddr, pc_exp, nxt_exp;
        bit exp_wr, is_ls, is_ldr, tk, wr_rdy;
        int body, len, exp_na, exp_nb, exp_nc, exp_ls, exp_rd, exp_wc, off, nxt;
        int nw, na, nb, nc, nls, nrd, nwc, wk, fetch_bad, dec_bad, addr_bad;
        opc = instr[15:11]; rn = instr[10:8]; rd = instr[7:5]; rm = instr[2:0];
        exp_wr = 0; exp_wn = 0; exp_vs = 0; exp_rnb = rm;
        exp_na = 0; exp_nb = 0; exp_nc = 0; exp_ls = 0; exp_rd = 0; exp_wc = 0;
        is_ldr = (opc == 5'b01100); is_ls = is_ldr || (opc == 5'b10000);
        tk = 0;
        case (opc)
            5'b11010: begin body = 3; exp_wr = 1; exp_wn = rn; exp_vs = 2'd2; end
            5'b11000, 5'b10111: begin body = 5; exp_wr = 1; exp_wn = rd; exp_nb = 1; exp_nc = 1; end
            5'b10100, 5'b10110: begin body = 6; exp_wr = 1; exp_wn = rd; exp_na = 1; exp_nb = 1; exp_nc = 1; end
            5'b10101: begin body = 5; exp_na = 1; exp_nb = 1; exp_ls = 1; end
            5'b01100: begin body = 6 + mw; exp_wr = 1; exp_wn = rd; exp_vs = 2'd3; exp_na = 1; exp_nc = 1; exp_rd = mw + 1; end
            5'b10000: begin body = 8 + mw; exp_na = 1; exp_nb = 1; exp_nc = 2; exp_wc = mw + 1; exp_rnb = rd; end
            5'b00100: begin
                body = 3;
                case (instr[10:8])
                    3'd0: tk = 1;
                    3'd1: tk = z;
                    3'd2: tk = !z;
                    3'd3: tk = (n != v);
                    3'd4: tk = (n != v) || z;
                    default: tk = 0;
                endcase
            end
            default: body = 2;
        endcase
        len = fw + 1 + body;
        off = instr[7] ? int'(instr[7:0]) - 256 : int'(instr[7:0]);
        nxt = (pc_m + 1 + (tk ? off : 0) + 1024) % 512;
        pc_exp = ADDR_W'(pc_m); nxt_exp = ADDR_W'(nxt); daddr = dpo[ADDR_W-1:0];
        datapath_out = dpo; Z = z; N = n; V = v;
        start_instr(instr, fw, mw);
        nw = 0; na = 0; nb = 0; nc = 0; nls = 0; nrd = 0; nwc = 0; wk = -1;
        fetch_bad = 0; dec_bad = 0; addr_bad = 0; wr_rdy = 0;
        wn = 0; vs = 0; rn_a = 0; rn_b = 0;
        for (int k = 0; k < len; k++) begin
            drive_inputs();
            if (k <= fw) begin
                if (mem_cmd !== 2'b01 || mem_addr !== pc_exp) fetch_bad++;
            end else begin
                if (ALUop !== instr[12:11] || shift !== instr[4:3] ||
                    sximm5 !== {{11{instr[4]}}, instr[4:0]} ||
                    sximm8 !== {{8{instr[7]}}, instr[7:0]} || shift_ctrl !== is_ls) dec_bad++;
                if (mem_cmd == 2'b01) begin nrd++; if (mem_addr !== daddr) addr_bad++; end
                if (mem_cmd == 2'b10) begin nwc++; if (mem_addr !== daddr) addr_bad++; end
            end
            if (halted !== 1'b0 || illegal !== 1'b0) dec_bad++;
            if (write === 1'b1) begin nw++; wn = writenum; vs = vsel; wk = k; wr_rdy = mem_ready; end
            if (loada === 1'b1) begin na++; rn_a = readnum; end
            if (loadb === 1'b1) begin nb++; rn_b = readnum; end
            if (loadc === 1'b1) nc++;
            if (loads === 1'b1) nls++;
            @(posedge clk); #1;
        end
        n_cmp++; if (fetch_bad != 0) begin n_bad++; $display("FAIL fetch instr=%h bad_cycles=%0d want 0", instr, fetch_bad); end
        n_cmp++; if (dec_bad != 0) begin n_bad++; $display("FAIL decode_fields instr=%h bad_cycles=%0d want 0", instr, dec_bad); end
        n_cmp++; if (nw != int'(exp_wr)) begin n_bad++; $display("FAIL write_count instr=%h got %0d want %0d", instr, nw, exp_wr); end
        if (exp_wr) begin
            n_cmp++; if (wn !== exp_wn || vs !== exp_vs) begin n_bad++; $display("FAIL writeback instr=%h got wn=%0d vsel=%0d want wn=%0d vsel=%0d", instr, wn, vs, exp_wn, exp_vs); end
            n_cmp++; if (wk != len - 1) begin n_bad++; $display("FAIL write_cycle instr=%h got %0d want %0d", instr, wk, len - 1); end
        end
        if (is_ldr) begin
            n_cmp++; if (wr_rdy !== 1'b1) begin n_bad++; $display("FAIL ldr_write_on_ready instr=%h got %0d want 1", instr, wr_rdy); end
        end
        n_cmp++;
        if (na != exp_na || nb != exp_nb || nc != exp_nc || nls != exp_ls) begin
            n_bad++; $display("FAIL enables instr=%h got a%0d b%0d c%0d s%0d want a%0d b%0d c%0d s%0d",
                              instr, na, nb, nc, nls, exp_na, exp_nb, exp_nc, exp_ls);
        end
        if (exp_na > 0) begin
            n_cmp++; if (rn_a !== rn) begin n_bad++; $display("FAIL loada_reg instr=%h got %0d want %0d", instr, rn_a, rn); end
        end
        if (exp_nb > 0) begin
            n_cmp++; if (rn_b !== exp_rnb) begin n_bad++; $display("FAIL loadb_reg instr=%h got %0d want %0d", instr, rn_b, exp_rnb); end
        end
        n_cmp++;
        if (nrd != exp_rd || nwc != exp_wc || addr_bad != 0) begin
            n_bad++; $display("FAIL data_phase instr=%h got rd=%0d wr=%0d addr_bad=%0d want rd=%0d wr=%0d addr_bad=0",
                              instr, nrd, nwc, addr_bad, exp_rd, exp_wc);
        end
        n_cmp++;
        if (mem_cmd !== 2'b01 || mem_addr !== nxt_exp || pc !== nxt_exp) begin
            n_bad++; $display("FAIL next_fetch instr=%h got cmd=%0d addr=%h pc=%h want cmd=1 addr=%h", instr, mem_cmd, mem_addr, pc, nxt_exp);
        end
        pc_m = nxt;
    endtask

    task automatic test_movi();
        run_instr({5'b11010, 3'd0, 8'hFD}, 0, 0, 16'h0000, 0, 0, 0);
    endtask

    task automatic test_ldr();
        run_instr({5'b01100, 3'd2, 3'd1, 2'b00, 3'd2}, 1, 3, 16'h0A5C, 0, 0, 0);
    endtask

    task automatic test_str();
        run_instr({5'b10000, 3'd3, 3'd4, 2'b00, 3'd1}, 0, 2, 16'h1234, 0, 0, 0);
    endtask

    task automatic test_branch();
        do_reset();
        run_instr({5'b00100, 3'd0, 8'hFA}, 0, 0, 16'h0, 0, 0, 0);
        run_instr({5'b00100, 3'd1, 8'hFE}, 0, 0, 16'h0, 1, 0, 0);
        do_reset();
        run_instr({5'b00100, 3'd0, 8'hFA}, 1, 0, 16'h0, 0, 0, 0);
        run_instr({5'b00100, 3'd1, 8'hFE}, 0, 0, 16'h0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [4:0] ops [10];
        int nops, idx;
        ops = '{5'b11010, 5'b11000, 5'b10111, 5'b10100, 5'b10101,
                5'b10110, 5'b01100, 5'b10000, 5'b00100, 5'b11111};
`ifdef CPU_ILLEGAL_TRAP_EN
        nops = 9;
`else
        nops = 10;
`endif
        for (int i = 0; i < 40; i++) begin
            idx = $urandom_range(0, nops - 1);
            run_instr({ops[idx], 11'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 3),
                      DATA_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset();
        logic [DATA_W*2+ADDR_W+34-1:0] obs;
        start_instr({5'b11010, 3'd5, 8'h11}, 10, 0);
        for (int k = 0; k < 3; k++) begin drive_inputs(); @(posedge clk); #1; end
        drive_inputs();
        #2 reset = 1'b1;
        #1;
        obs = {mem_cmd, mem_addr, write, loada, loadb, loadc, loads, asel, bsel, nsel, vsel,
               readnum, writenum, ALUop, shift, sximm5, sximm8, shift_ctrl, halted, illegal};
        n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL reset_outputs got %h want 0", obs); end
        n_cmp++; if (pc !== ADDR_W'(RESET_PC)) begin n_bad++; $display("FAIL reset_pc got %h want %h", pc, RESET_PC); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_cmd !== 2'b00) begin n_bad++; $display("FAIL rst_state_cmd got %0d want 0", mem_cmd); end
        @(posedge clk); #1;
        n_cmp++; if (mem_cmd !== 2'b01 || mem_addr !== ADDR_W'(RESET_PC)) begin
            n_bad++; $display("FAIL first_fetch got cmd=%0d addr=%h want cmd=1 addr=%h", mem_cmd, mem_addr, RESET_PC);
        end
        pc_m = RESET_PC;
    endtask

    task automatic test_halt();
        int bad;
        start_instr(16'hE000, 1, 0);
        for (int k = 0; k < 4; k++) begin drive_inputs(); @(posedge clk); #1; end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            drive_inputs();
            if (halted !== 1'b1 || mem_cmd !== 2'b00 || illegal !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL halt_hold bad_cycles=%0d want 0", bad); end
        do_reset();
    endtask

    task automatic test_illegal();
`ifdef CPU_ILLEGAL_TRAP_EN
        int bad;
        start_instr(16'hF8A3, 0, 0);
        for (int k = 0; k < 3; k++) begin drive_inputs(); @(posedge clk); #1; end
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            drive_inputs();
            if (halted !== 1'b1 || illegal !== 1'b1 || mem_cmd !== 2'b00) bad++;
            @(posedge clk); #1;
        end
        n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL illegal_trap bad_cycles=%0d want 0", bad); end
        do_reset();
        n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_cleared got %0d want 0", illegal); end
`else
        run_instr(16'hF8A3, 1, 0, 16'h0, 0, 0, 0);
        run_instr({5'b11010, 3'd7, 8'h42}, 0, 0, 16'h0, 0, 0, 0);
`endif
    endtask

    initial begin
        do_reset();
        test_movi();
        test_ldr();
        test_str();
        test_branch();
        test_random();
        test_reset();
        test_halt();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
